// File: rtl/arith_op_ctrl.sv
// arith_op_ctrl -- multi-cycle unsigned arithmetic controller.
//
// This block accepts one request when i_valid and o_ready are both high. It
// computes add, sub, mul, div, mod or pow on the 8-bit operands and then
// reports a zero-extended 32-bit result with a one-cycle o_done pulse.
//   i_clk, i_rst_n   clock; asynchronous active-low reset
//   i_valid/o_ready  request handshake (o_ready high only in IDLE)
//   i_op             0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 pow, 6/7 illegal
//   i_a, i_b         unsigned operands
//   o_result, o_err  result and error flag, held until the next completion
//   o_done           one-cycle completion pulse
//   o_busy           high whenever the controller is not IDLE
//
// Optional macro ARITH_OP_POW_EN compiles in the pow datapath. When it is
// undefined, opcode 5 is treated as illegal.
module arith_op_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_op,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic [31:0] o_result,
    output logic        o_done,
    output logic        o_err,
    output logic        o_busy
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
`ifdef ARITH_OP_POW_EN
    localparam logic [2:0] OP_POW = 3'd5;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic        last;
    logic [2:0]  op_q;
    logic [7:0]  a_q, b_q;
    logic [7:0]  cnt_q, cnt_init;      // remaining CALC cycles minus one
    logic [7:0]  div_rem_q, div_quo_q;
    logic [8:0]  div_shift;
    logic        div_ge;
    logic [7:0]  div_rem_nxt, div_quo_nxt;
    logic [15:0] prod;
    logic [31:0] res_nxt;
    logic        err_nxt;
`ifdef ARITH_OP_POW_EN
    logic [31:0] pow_acc_q, pow_acc_nxt;
`endif

    assign last = (cnt_q == 8'd0);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: if (last) state_nxt = DONE;
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration count chosen at accept time. Divide-by-zero and
    // single-cycle ops finish on the first CALC edge.
    always_comb begin
        cnt_init = 8'd0;
        case (i_op)
            OP_DIV, OP_MOD: cnt_init = (i_b == 8'd0) ? 8'd0 : 8'd7;
`ifdef ARITH_OP_POW_EN
            OP_POW:         cnt_init = (i_b == 8'd0) ? 8'd0 : i_b - 8'd1;
`endif
            default:        cnt_init = 8'd0;
        endcase
    end

    // One restoring-division step per CALC cycle. The quotient register
    // starts as the dividend and shifts quotient bits in from the right.
    always_comb begin
        div_shift   = {div_rem_q, div_quo_q[7]};
        div_ge      = (div_shift >= {1'b0, b_q});
        div_rem_nxt = div_ge ? 8'(div_shift - {1'b0, b_q}) : div_shift[7:0];
        div_quo_nxt = {div_quo_q[6:0], div_ge};
        prod        = {8'd0, a_q} * {8'd0, b_q};
`ifdef ARITH_OP_POW_EN
        pow_acc_nxt = pow_acc_q * {24'd0, a_q};
`endif
    end

    // Final result, evaluated on the last CALC cycle
    always_comb begin
        res_nxt = 32'd0;
        err_nxt = 1'b0;
        case (op_q)
            OP_ADD: res_nxt = {23'd0, {1'b0, a_q} + {1'b0, b_q}};
            OP_SUB: res_nxt = {24'd0, a_q - b_q};
            OP_MUL: res_nxt = {16'd0, prod};
            OP_DIV: begin
                if (b_q == 8'd0) err_nxt = 1'b1;
                else             res_nxt = {24'd0, div_quo_nxt};
            end
            OP_MOD: begin
                if (b_q == 8'd0) err_nxt = 1'b1;
                else             res_nxt = {24'd0, div_rem_nxt};
            end
`ifdef ARITH_OP_POW_EN
            OP_POW: res_nxt = (b_q == 8'd0) ? 32'd1 : pow_acc_nxt;
`endif
            default: err_nxt = 1'b1;
        endcase
    end

    // Operand latch, iteration state and result register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q      <= 3'd0;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            cnt_q     <= 8'd0;
            div_rem_q <= 8'd0;
            div_quo_q <= 8'd0;
`ifdef ARITH_OP_POW_EN
            pow_acc_q <= 32'd0;
`endif
            o_result  <= 32'd0;
            o_err     <= 1'b0;
        end else if (accept) begin
            op_q      <= i_op;
            a_q       <= i_a;
            b_q       <= i_b;
            cnt_q     <= cnt_init;
            div_rem_q <= 8'd0;
            div_quo_q <= i_a;
`ifdef ARITH_OP_POW_EN
            pow_acc_q <= 32'd1;
`endif
        end else if (state == CALC) begin
            div_rem_q <= div_rem_nxt;
            div_quo_q <= div_quo_nxt;
`ifdef ARITH_OP_POW_EN
            pow_acc_q <= pow_acc_nxt;
`endif
            if (last) begin
                o_result <= res_nxt;
                o_err    <= err_nxt;
            end else begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_arith_op_ctrl.sv
module tb_arith_op_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_op;
    logic [7:0]  i_a, i_b;
    logic [31:0] o_result;
    logic        o_done, o_err, o_busy;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] prev_res;
    logic        prev_err;

    arith_op_ctrl dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .o_result(o_result),
        .o_done  (o_done),
        .o_err   (o_err),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: plain arithmetic on the operation definitions
    function automatic void ref_model(input logic [2:0] op, input logic [7:0] a,
                                      input logic [7:0] b, output logic [31:0] r,
                                      output logic e, output int n);
        int ia, ib;
        ia = a;
        ib = b;
        r  = 0;
        e  = 1'b0;
        n  = 1;
        case (op)
            3'd0: r = ia + ib;
            3'd1: r = (ia - ib + 256) % 256;
            3'd2: r = ia * ib;
            3'd3: if (ib == 0) e = 1'b1; else begin r = ia / ib; n = 8; end
            3'd4: if (ib == 0) e = 1'b1; else begin r = ia % ib; n = 8; end
`ifdef ARITH_OP_POW_EN
            3'd5: begin
                r = 1;
                for (int i = 0; i < ib; i++) r = r * a;
                n = (ib == 0) ? 1 : ib;
            end
`endif
            default: e = 1'b1;
        endcase
    endfunction

    // Issue one request at a negedge and follow it to completion.
    // hold=1 keeps i_valid high (with different operands) throughout.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input bit hold);
        logic [31:0] er;
        logic        ee;
        int          n, j;
        ref_model(op, a, b, er, ee, n);
        check("ready_idle", o_ready, 1);
        i_valid = 1'b1;
        i_op = op;
        i_a  = a;
        i_b  = b;
        @(posedge i_clk);
        @(negedge i_clk);
        if (hold) begin
            i_op = 3'd0;
            i_a  = 8'hAA;
            i_b  = 8'h55;
        end else begin
            i_valid = 1'b0;
        end
        j = 0;
        while (o_done !== 1'b1 && j < 400) begin
            check("busy_calc", o_busy, 1);
            check("ready_calc", o_ready, 0);
            check("result_hold_calc", o_result, prev_res);
            check("err_hold_calc", o_err, prev_err);
            @(negedge i_clk);
            j++;
        end
        check("latency", j, n);
        check("result", o_result, er);
        check("err", o_err, ee);
        check("busy_done", o_busy, 1);
        check("ready_done", o_ready, 0);
        @(negedge i_clk);
        check("done_width", o_done, 0);
        check("busy_after", o_busy, 0);
        check("ready_after", o_ready, 1);
        check("result_kept", o_result, er);
        prev_res = er;
        prev_err = ee;
    endtask

    initial begin
        logic [2:0] rop;
        logic [7:0] ra, rb;

        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_op     = 3'd0;
        i_a      = 8'd0;
        i_b      = 8'd0;
        prev_res = 32'd0;
        prev_err = 1'b0;
        #1;
        check("rst_result", o_result, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", o_ready, 1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_op(3'd0, 8'd7, 8'd3, 0);
        run_op(3'd1, 8'd7, 8'd3, 0);
        run_op(3'd1, 8'd3, 8'd7, 0);
        run_op(3'd0, 8'd255, 8'd255, 0);
        run_op(3'd2, 8'd10, 8'd2, 0);
        run_op(3'd3, 8'd19, 8'd4, 0);
        run_op(3'd4, 8'd19, 8'd4, 0);
        run_op(3'd2, 8'd255, 8'd255, 0);
        run_op(3'd3, 8'd255, 8'd1, 0);
        run_op(3'd3, 8'd10, 8'd0, 0);
        run_op(3'd4, 8'd10, 8'd0, 0);
        run_op(3'd7, 8'd5, 8'd5, 0);
        run_op(3'd6, 8'd5, 8'd5, 0);
        run_op(3'd5, 8'd2, 8'd3, 0);
        run_op(3'd5, 8'd7, 8'd3, 0);
        run_op(3'd5, 8'd10, 8'd0, 0);
        run_op(3'd5, 8'd2, 8'd40, 0);

        // Back-pressure: valid stays high; the second request goes in
        // at the edge after DONE
        run_op(3'd3, 8'd200, 8'd7, 1);
        run_op(3'd2, 8'd12, 8'd12, 0);

        // Reset in the middle of a divide
        run_op(3'd0, 8'd200, 8'd100, 0);
        i_valid = 1'b1;
        i_op = 3'd3;
        i_a  = 8'd19;
        i_b  = 8'd4;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("mid_busy", o_busy, 1);
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_result", o_result, 0);
        check("mid_rst_done", o_done, 0);
        check("mid_rst_err", o_err, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_ready", o_ready, 1);
        repeat (3) begin
            @(negedge i_clk);
            check("rst_no_done", o_done, 0);
        end
        i_rst_n  = 1'b1;
        prev_res = 32'd0;
        prev_err = 1'b0;
        run_op(3'd0, 8'd1, 8'd1, 0);

        for (int t = 0; t < 40; t++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            if (rop == 3'd5) rb = 8'($urandom_range(0, 12));
            if ((rop == 3'd3 || rop == 3'd4) && ($urandom_range(0, 4) == 0)) rb = 8'd0;
            run_op(rop, ra, rb, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arith_op_ctrl.md
ARITH_OP_CTRL -- requirements
Module: arith_op_ctrl

Interface
REQ-001 SHALL have port i_clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-003 SHALL have port i_valid, input, 1 bit: the request strobe.
REQ-004 SHALL have port o_ready, output, 1 bit: the controller accepts a request this cycle.
REQ-005 SHALL have port i_op, input, 3 bits: the opcode, encoded 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 pow; 6 and 7 are illegal.
REQ-006 SHALL have port i_a, input, 8 bits: unsigned operand A.
REQ-007 SHALL have port i_b, input, 8 bits: unsigned operand B.
REQ-008 SHALL have port o_result, output, 32 bits: the zero-extended result, held until the next completion.
REQ-009 SHALL have port o_done, output, 1 bit: a one-cycle completion pulse.
REQ-010 SHALL have port o_err, output, 1 bit: the error flag, valid with o_done and held with o_result.
REQ-011 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL use a state machine with states IDLE, CALC and DONE; o_ready SHALL equal (state == IDLE).
REQ-013 SHALL accept a request at edge k when i_valid and o_ready are both 1, latch i_op/i_a/i_b and enter CALC; i_valid SHALL be ignored in any other state.
REQ-014 SHALL stay in CALC for N cycles, write o_result/o_err at edge k+N, enter DONE, then return to IDLE at edge k+N+1.
REQ-015 SHALL drive o_done high only in DONE, for exactly one cycle (sampled high at edge k+N+1).
REQ-016 SHALL use N=1 for add, sub, mul, illegal opcodes and divide-by-zero.
REQ-017 SHALL compute add as the 9-bit sum, sub as the 8-bit difference modulo 256, and mul as the 16-bit product.
REQ-018 SHALL implement div/mod as an iterative restoring divider with N=8; div returns the 8-bit quotient and mod returns the 8-bit remainder.
REQ-019 SHALL, when i_b=0 for div or mod, return o_result=0 with o_err=1.
REQ-020 SHALL implement pow as repeated multiplication of a 32-bit accumulator by A, with N=max(B,1); B=0 SHALL yield 1, and only the low 32 bits SHALL be retained (overflow is not an error).
REQ-021 SHALL, for illegal opcodes, return o_result=0 with o_err=1.
REQ-022 SHALL return o_err=0 for every legal, non-faulting operation.
REQ-023 SHALL keep o_result and o_err unchanged while in CALC, preserving the previous result until edge k+N.

Reset
REQ-024 SHALL, while i_rst_n=0, immediately force state=IDLE, o_result=0, o_done=0, o_err=0, o_busy=0 and o_ready=1, and clear the iteration counter and accumulators.
REQ-025 SHALL abort any in-flight operation on reset without producing an o_done pulse.
REQ-026 SHALL accept a new request on the first edge after reset deassertion.

Configuration
REQ-027 SHALL, when macro ARITH_OP_POW_EN is defined, compile in the pow datapath and counter as specified in REQ-020.
REQ-028 SHALL, when ARITH_OP_POW_EN is undefined, omit the pow logic entirely and treat opcode 5 as illegal (N=1, o_result=0, o_err=1).

Verification
REQ-029 SHALL cover add/sub: add 7,3 -> 10; sub 7,3 -> 4; sub 3,7 -> 252; add 255,255 -> 510; each with o_err=0, o_done one cycle wide, sampled high at edge k+2.
REQ-030 SHALL cover mul/div/mod: mul 10,2 -> 20; div 19,4 -> 4; mod 19,4 -> 3; o_done sampled high at edge k+9 for div/mod; o_ready=0 and o_busy=1 throughout.
REQ-031 SHALL cover pow (macro on): 7,3 -> 343 at edge k+4; 10,0 -> 1 at edge k+2; 2,40 -> 0 with o_err=0 at edge k+41.
REQ-032 SHALL cover errors: div 10,0 -> o_result 0, o_err 1 at edge k+2; opcode 7 -> o_err 1; macro off, opcode 5 with 2,3 -> o_err 1, o_result 0.
REQ-033 SHALL cover reset mid-operation: assert i_rst_n=0 three cycles into div 19,4 -> all outputs cleared immediately and no o_done pulse; after release, add 1,1 -> 2.
REQ-034 SHALL cover back-pressure: i_valid held high while busy -> only one request accepted; the next request is accepted at the edge after DONE, and o_result holds its prior value during CALC.
